// File: rtl/spi_seq_arb.sv
// Round-robin sequencer that shares one spi_top register port between NREQ byte requesters.
// Each granted byte runs select/load/start/poll/read/deselect; bursts keep the grant until ReqLast.
module spi_seq_arb #(
  parameter int         NREQ      = 2,
  parameter logic [1:0] ADDR_CTRL = 2'd0,
  parameter logic [1:0] ADDR_SS   = 2'd1,
  parameter logic [1:0] ADDR_TX   = 2'd2,
  parameter logic [1:0] ADDR_RX   = 2'd3,
  parameter logic [7:0] CFG       = 8'h00,
  parameter int         START_BIT = 7,
  parameter int         END_BIT   = 6,
  parameter logic [7:0] SS_IDLE   = 8'hFF,
  parameter int         TIMEOUT   = 1023
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [NREQ-1:0]     Req,
  input  logic [3*NREQ-1:0]   ReqSlave,
  input  logic [8*NREQ-1:0]   ReqTx,
  input  logic [NREQ-1:0]     ReqLast,
  output logic [NREQ-1:0]     Ack,
  output logic [7:0]          RxByte,
  output logic                Err,
  output logic                Busy,
  output logic [1:0]          Addr,
  output logic                Wr,
  output logic [7:0]          DataWr,
  input  logic [7:0]          DataRd
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ARB   = 4'd1;
  localparam logic [3:0] S_SEL   = 4'd2;
  localparam logic [3:0] S_LDTX  = 4'd3;
  localparam logic [3:0] S_START = 4'd4;
  localparam logic [3:0] S_CLR   = 4'd5;
  localparam logic [3:0] S_POLL  = 4'd6;
  localparam logic [3:0] S_READ  = 4'd7;
  localparam logic [3:0] S_DESEL = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  logic [3:0]    state;
  logic [GW-1:0] grant;
  logic [GW-1:0] rr_ptr;
  logic          locked;
  logic [CW-1:0] poll_cnt;
  logic [GW-1:0] pick;
  logic          pick_valid;

  // Search starts at the round-robin pointer and wraps, so the first hit is the fairest choice.
  always_comb begin
    pick       = rr_ptr;
    pick_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = int'(rr_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!pick_valid && Req[k[GW-1:0]]) begin
        pick       = k[GW-1:0];
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      locked   <= 1'b0;
      poll_cnt <= '0;
      RxByte   <= 8'h00;
      Err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (locked && Req[grant]) state <= S_LDTX;
          else if (|Req)            state <= S_ARB;
        end
        S_ARB: begin
          if (pick_valid) begin
            grant  <= pick;
            locked <= 1'b1;
            state  <= S_SEL;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_SEL:   state <= S_LDTX;
        S_LDTX:  state <= S_START;
        S_START: state <= S_CLR;
        S_CLR: begin
          poll_cnt <= '0;
          state    <= S_POLL;
        end
        // A timeout always deselects, which also releases the grant.
        S_POLL: begin
          if (DataRd[END_BIT]) begin
            state <= S_READ;
          end else if (poll_cnt == CW'(TIMEOUT)) begin
            Err   <= 1'b1;
            state <= S_DESEL;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        S_READ: begin
          RxByte <= DataRd;
          Err    <= 1'b0;
          state  <= ReqLast[grant] ? S_DESEL : S_DONE;
        end
        S_DESEL: begin
          locked <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (!locked) begin
            if (grant == GW'(NREQ - 1)) rr_ptr <= '0;
            else                        rr_ptr <= grant + 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    Wr     = 1'b0;
    Addr   = ADDR_CTRL;
    DataWr = 8'h00;
    Ack    = '0;
    case (state)
      S_SEL: begin
        Wr     = 1'b1;
        Addr   = ADDR_SS;
        DataWr = SS_IDLE & ~(8'h01 << ReqSlave[3*int'(grant) +: 3]);
      end
      S_LDTX: begin
        Wr     = 1'b1;
        Addr   = ADDR_TX;
        DataWr = ReqTx[8*int'(grant) +: 8];
      end
      S_START: begin
        Wr     = 1'b1;
        DataWr = CFG | (8'h01 << START_BIT);
      end
      S_CLR: begin
        Wr     = 1'b1;
        DataWr = CFG;
      end
      S_READ:  Addr = ADDR_RX;
      S_DESEL: begin
        Wr     = 1'b1;
        Addr   = ADDR_SS;
        DataWr = SS_IDLE;
      end
      S_DONE:  Ack[grant] = 1'b1;
      default: ;
    endcase
  end

  assign Busy = (state != S_IDLE) || locked;

endmodule
